// File: rtl/focus_sweep_ctrl.sv
// Autofocus sequencer: sweeps the focus motor, scores Sobel sharpness over an ROI per
// position, then drives the motor back to the sharpest position.
module focus_sweep_ctrl #(
  parameter int unsigned MAX_POS       = 32,
  parameter int unsigned POS_W         = 6,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned ROI_X0        = 80,
  parameter int unsigned ROI_X1        = 239,
  parameter int unsigned ROI_Y0        = 60,
  parameter int unsigned ROI_Y1        = 179,
  parameter int unsigned SCORE_W       = 28
) (
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_start,
  input  logic               pixel_valid,
  input  logic [9:0]         x_pixel,
  input  logic [9:0]         y_pixel,
  input  logic [10:0]        integrated_data,
  input  logic               step_ack,
  output logic               sobel_en,
  output logic               step_req,
  output logic               step_dir,
  output logic [POS_W-1:0]   cur_pos,
  output logic [POS_W-1:0]   best_pos,
  output logic [SCORE_W-1:0] focus_score,
  output logic               score_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned FCNT_W = $clog2(SETTLE_FRAMES + 1) + 1;
  localparam int unsigned ACC_W  = SCORE_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_COMPARE, S_STEP, S_RETURN, S_FINISH
  } state_t;

  state_t             state;
  logic [FCNT_W-1:0]  frame_cnt;
  logic [SCORE_W-1:0] acc;
  logic [SCORE_W-1:0] best_score;
  logic               in_roi;
  logic [ACC_W-1:0]   acc_sum;
  logic [SCORE_W-1:0] acc_next;

  // ROI window test and saturating accumulate
  always_comb begin
    in_roi = pixel_valid
             && (x_pixel >= 10'(ROI_X0)) && (x_pixel <= 10'(ROI_X1))
             && (y_pixel >= 10'(ROI_Y0)) && (y_pixel <= 10'(ROI_Y1));
    acc_sum  = {1'b0, acc} + ACC_W'(integrated_data);
    acc_next = acc_sum[SCORE_W] ? '1 : acc_sum[SCORE_W-1:0];
  end

  // Sequencer; sobel_en and busy are registered alongside each state transition
  always_ff @(posedge clk_25MHz or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      frame_cnt   <= '0;
      acc         <= '0;
      best_score  <= '0;
      sobel_en    <= 1'b0;
      step_req    <= 1'b0;
      step_dir    <= 1'b0;
      cur_pos     <= '0;
      best_pos    <= '0;
      focus_score <= '0;
      score_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_pos    <= '0;
            best_pos   <= '0;
            best_score <= '0;
            frame_cnt  <= '0;
            busy       <= 1'b1;
            sobel_en   <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (frame_start) begin
            if (frame_cnt == FCNT_W'(SETTLE_FRAMES)) begin
              acc   <= '0;
              state <= S_MEASURE;
            end else begin
              frame_cnt <= frame_cnt + FCNT_W'(1);
            end
          end
        end
        S_MEASURE: begin
          // The closing frame_start publishes the score; its own pixel is not summed
          if (frame_start) begin
            focus_score <= acc;
            score_valid <= 1'b1;
            state       <= S_COMPARE;
          end else if (in_roi) begin
            acc <= acc_next;
          end
        end
        S_COMPARE: begin
          sobel_en <= 1'b0;
          if (acc > best_score) begin
            best_score <= acc;
            best_pos   <= cur_pos;
          end
          if (cur_pos == POS_W'(MAX_POS - 1)) begin
            state <= S_RETURN;
          end else begin
            step_dir <= 1'b1;
            step_req <= 1'b1;
            state    <= S_STEP;
          end
        end
        S_STEP: begin
          if (step_ack) begin
            step_req <= 1'b0;
            if (step_dir) begin
              cur_pos   <= cur_pos + POS_W'(1);
              frame_cnt <= '0;
              sobel_en  <= 1'b1;
              state     <= S_SETTLE;
            end else begin
              cur_pos <= cur_pos - POS_W'(1);
              state   <= S_RETURN;
            end
          end
        end
        S_RETURN: begin
          if (cur_pos > best_pos) begin
            step_dir <= 1'b0;
            step_req <= 1'b1;
            state    <= S_STEP;
          end else begin
            done  <= 1'b1;
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_focus_sweep_ctrl.sv
// Directed bench for focus_sweep_ctrl on a reduced 16x8 frame with an 8x4 ROI.
module tb_focus_sweep_ctrl;

  localparam int unsigned MAX_POS = 8, POS_W = 4, SETTLE_FRAMES = 1, SCORE_W = 12;
  localparam int unsigned ROI_X0 = 4, ROI_X1 = 11, ROI_Y0 = 2, ROI_Y1 = 5;
  localparam int unsigned FRAME_W = 16, FRAME_H = 8, ROI_PIX = 32;

  logic               clk_25MHz = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               frame_start = 1'b0;
  logic               pixel_valid = 1'b0;
  logic [9:0]         x_pixel = '0;
  logic [9:0]         y_pixel = '0;
  logic [10:0]        integrated_data = '0;
  logic               step_ack = 1'b0;
  logic               sobel_en, step_req, step_dir, score_valid, busy, done;
  logic [POS_W-1:0]   cur_pos, best_pos;
  logic [SCORE_W-1:0] focus_score;

  focus_sweep_ctrl #(
    .MAX_POS(MAX_POS), .POS_W(POS_W), .SETTLE_FRAMES(SETTLE_FRAMES),
    .ROI_X0(ROI_X0), .ROI_X1(ROI_X1), .ROI_Y0(ROI_Y0), .ROI_Y1(ROI_Y1),
    .SCORE_W(SCORE_W)
  ) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .start(start), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .integrated_data(integrated_data), .step_ack(step_ack), .sobel_en(sobel_en),
    .step_req(step_req), .step_dir(step_dir), .cur_pos(cur_pos), .best_pos(best_pos),
    .focus_score(focus_score), .score_valid(score_valid), .busy(busy), .done(done)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int fs_cyc = 0, sv_lat = -1, done_cnt = 0;
  int fwd = 0, rev = 0, unstable = 0, ack_err = 0, model_pos = 0;
  int scores[$];
  logic [POS_W-1:0] done_best = '0, done_cur = '0;
  logic done_prev = 1'b0, busy_after = 1'b1;
  logic [1:0] start_flags = '0;

  always @(posedge clk_25MHz) cyc <= cyc + 1;

  // Passive observer of score and completion pulses
  always @(negedge clk_25MHz) begin
    if (score_valid) begin
      scores.push_back(int'(focus_score));
      sv_lat = cyc - fs_cyc;
    end
    if (done_prev) busy_after = busy;
    if (done) begin
      done_cnt++;
      done_best = best_pos;
      done_cur  = cur_pos;
    end
    done_prev = done;
  end

  function automatic int pix_val(input int mode, input int pos);
    int d;
    d = (pos > 5) ? pos - 5 : 5 - pos;
    case (mode)
      0: return 10;
      1: return 100 - 10 * d;
      2: return (pos == 2 || pos == 6) ? 90 : 20;
      default: return 2047;
    endcase
  endfunction

  function automatic int exp_score(input int v);
    int s;
    s = v * int'(ROI_PIX);
    return (s > 4095) ? 4095 : s;
  endfunction

  // One frame: frame_start cycle carries a bogus ROI pixel that must never count
  task automatic send_frame(input int v, input bit inject);
    @(negedge clk_25MHz);
    frame_start = 1'b1; pixel_valid = 1'b1;
    x_pixel = 10'(ROI_X0); y_pixel = 10'(ROI_Y0); integrated_data = 11'(2047);
    fs_cyc = cyc;
    for (int y = 0; y < int'(FRAME_H); y++) begin
      for (int x = 0; x < int'(FRAME_W); x++) begin
        @(negedge clk_25MHz);
        frame_start = 1'b0; pixel_valid = 1'b1;
        x_pixel = 10'(x); y_pixel = 10'(y);
        if (x >= int'(ROI_X0) && x <= int'(ROI_X1) && y >= int'(ROI_Y0) && y <= int'(ROI_Y1))
          integrated_data = 11'(v);
        else
          integrated_data = 11'(2047);
        step_ack = inject && (y == 3) && (x == 6);
        start    = inject && (y == 3) && (x == 6);
      end
      @(negedge clk_25MHz);
      pixel_valid = 1'b0; x_pixel = 10'(6); y_pixel = 10'(3); integrated_data = 11'(2047);
      step_ack = 1'b0; start = 1'b0;
    end
    @(negedge clk_25MHz);
  endtask

  task automatic do_ack(input int dly);
    logic d0, r0;
    logic [POS_W-1:0] p0;
    int exp_pos;
    d0 = step_dir; p0 = cur_pos;
    repeat (dly) begin
      @(negedge clk_25MHz);
      if (step_req !== 1'b1 || step_dir !== d0 || cur_pos !== p0) unstable++;
    end
    step_ack = 1'b1;
    @(negedge clk_25MHz);
    step_ack = 1'b0;
    r0 = step_req;
    exp_pos = d0 ? model_pos + 1 : model_pos - 1;
    if (d0) fwd++; else rev++;
    if (int'(cur_pos) != exp_pos || r0 !== 1'b0) ack_err++;
    model_pos = exp_pos;
  endtask

  task automatic service(input int dly);
    for (int k = 0; k < 40; k++) begin
      if (step_req === 1'b1) do_ack(dly);
      @(negedge clk_25MHz);
    end
  endtask

  task automatic run_sweep(input int mode, input int dly);
    int d0;
    scores.delete();
    fwd = 0; rev = 0; unstable = 0; ack_err = 0; model_pos = 0; d0 = done_cnt;
    @(negedge clk_25MHz); start = 1'b1;
    @(negedge clk_25MHz); start = 1'b0;
    start_flags = {busy, sobel_en};
    for (int f = 0; f < 40 && done_cnt == d0; f++) begin
      send_frame(pix_val(mode, model_pos), 1'b0);
      service(dly);
    end
    repeat (4) @(negedge clk_25MHz);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    n_checks++;
    if ({sobel_en, step_req, step_dir, cur_pos, best_pos, focus_score, score_valid, busy, done} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
        {sobel_en, step_req, step_dir, cur_pos, best_pos, focus_score, score_valid, busy, done});
    end
    reset = 1'b1;
    @(negedge clk_25MHz); frame_start = 1'b1; step_ack = 1'b1;
    @(negedge clk_25MHz); frame_start = 1'b0; step_ack = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    n_checks++;
    if ({sobel_en, step_req, step_dir, cur_pos, best_pos, focus_score, score_valid, busy, done} !== '0) begin
      n_fail++; $display("FAIL idle_stray_pulses: got %h expected 0",
        {sobel_en, step_req, step_dir, cur_pos, best_pos, focus_score, score_valid, busy, done});
    end
  endtask

  task automatic test_constant();
    int d0;
    d0 = done_cnt;
    run_sweep(0, 2);
    n_checks++;
    if (start_flags !== 2'b11) begin n_fail++; $display("FAIL start_latency: busy,sobel_en got %b expected 11", start_flags); end
    n_checks++;
    if (sv_lat != 1) begin n_fail++; $display("FAIL score_latency: got %0d expected 1", sv_lat); end
    n_checks++;
    if (scores.size() != int'(MAX_POS)) begin n_fail++; $display("FAIL const_score_count: got %0d expected %0d", scores.size(), MAX_POS); end
    else for (int p = 0; p < int'(MAX_POS); p++) begin
      n_checks++;
      if (scores[p] != 320) begin n_fail++; $display("FAIL const_score[%0d]: got %0d expected 320", p, scores[p]); end
    end
    n_checks++;
    if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL const_done: got %0d pulses expected 1", done_cnt - d0); end
    n_checks++;
    if (fwd != 7 || rev != 7) begin n_fail++; $display("FAIL const_steps: got fwd %0d rev %0d expected 7 7", fwd, rev); end
    n_checks++;
    if (done_best !== 4'd0 || done_cur !== 4'd0) begin n_fail++; $display("FAIL const_tie_best: got best %0d cur %0d expected 0 0", done_best, done_cur); end
    n_checks++;
    if (ack_err != 0 || unstable != 0) begin n_fail++; $display("FAIL const_handshake: got ack_err %0d unstable %0d expected 0 0", ack_err, unstable); end
  endtask

  task automatic test_handshake();
    scores.delete();
    fwd = 0; rev = 0; unstable = 0; ack_err = 0; model_pos = 0;
    @(negedge clk_25MHz); start = 1'b1;
    @(negedge clk_25MHz); start = 1'b0;
    send_frame(10, 1'b0);
    send_frame(10, 1'b1);
    send_frame(10, 1'b0);
    n_checks++;
    if (step_req !== 1'b1 || step_dir !== 1'b1 || cur_pos !== 4'd0) begin
      n_fail++; $display("FAIL hs_step_req: got req %b dir %b pos %0d expected 1 1 0", step_req, step_dir, cur_pos);
    end
    n_checks++;
    if (scores.size() != 1 || scores[0] != 320) begin
      n_fail++; $display("FAIL hs_stray_ignored: got %0d scores first %0d expected 1 score 320", scores.size(), (scores.size() > 0) ? scores[0] : -1);
    end
    do_ack(100);
    n_checks++;
    if (unstable != 0) begin n_fail++; $display("FAIL hs_stable: got %0d unstable cycles expected 0", unstable); end
    n_checks++;
    if (ack_err != 0 || cur_pos !== 4'd1) begin n_fail++; $display("FAIL hs_ack_edge: got pos %0d err %0d expected 1 0", cur_pos, ack_err); end
  endtask

  task automatic test_reset_mid_step();
    send_frame(10, 1'b0);
    send_frame(10, 1'b0);
    send_frame(10, 1'b0);
    n_checks++;
    if (step_req !== 1'b1) begin n_fail++; $display("FAIL rst_step_setup: got step_req %b expected 1", step_req); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({step_req, sobel_en, busy, cur_pos} !== '0) begin
      n_fail++; $display("FAIL rst_mid_step: got req %b en %b busy %b pos %0d expected 0 0 0 0", step_req, sobel_en, busy, cur_pos);
    end
    @(negedge clk_25MHz); reset = 1'b1;
  endtask

  task automatic test_reset_mid_measure();
    @(negedge clk_25MHz); start = 1'b1;
    @(negedge clk_25MHz); start = 1'b0;
    send_frame(10, 1'b0);
    @(negedge clk_25MHz); frame_start = 1'b1;
    @(negedge clk_25MHz); frame_start = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    n_checks++;
    if (sobel_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_meas_setup: got en %b busy %b expected 1 1", sobel_en, busy); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({step_req, sobel_en, busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_measure: got req %b en %b busy %b expected 0 0 0", step_req, sobel_en, busy);
    end
    @(negedge clk_25MHz); reset = 1'b1;
    repeat (2) @(negedge clk_25MHz);
  endtask

  task automatic test_peak();
    int d0;
    d0 = done_cnt;
    run_sweep(1, 2);
    n_checks++;
    if (scores.size() != int'(MAX_POS)) begin n_fail++; $display("FAIL peak_score_count: got %0d expected %0d", scores.size(), MAX_POS); end
    else for (int p = 0; p < int'(MAX_POS); p++) begin
      n_checks++;
      if (scores[p] != exp_score(pix_val(1, p))) begin
        n_fail++; $display("FAIL peak_score[%0d]: got %0d expected %0d", p, scores[p], exp_score(pix_val(1, p)));
      end
    end
    n_checks++;
    if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL peak_done: got %0d pulses expected 1", done_cnt - d0); end
    n_checks++;
    if (fwd != 7 || rev != 2) begin n_fail++; $display("FAIL peak_steps: got fwd %0d rev %0d expected 7 2", fwd, rev); end
    n_checks++;
    if (done_best !== 4'd5 || done_cur !== 4'd5) begin n_fail++; $display("FAIL peak_best: got best %0d cur %0d expected 5 5", done_best, done_cur); end
    n_checks++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL peak_busy_fall: got %b expected 0", busy_after); end
    n_checks++;
    if (ack_err != 0 || unstable != 0) begin n_fail++; $display("FAIL peak_handshake: got ack_err %0d unstable %0d expected 0 0", ack_err, unstable); end
  endtask

  task automatic test_tie();
    run_sweep(2, 1);
    n_checks++;
    if (scores.size() != int'(MAX_POS) || scores[2] != 2880 || scores[6] != 2880 || scores[0] != 640) begin
      n_fail++; $display("FAIL tie_scores: got n %0d s2 %0d s6 %0d expected 8 2880 2880", scores.size(),
        (scores.size() > 6) ? scores[2] : -1, (scores.size() > 6) ? scores[6] : -1);
    end
    n_checks++;
    if (done_best !== 4'd2 || done_cur !== 4'd2) begin n_fail++; $display("FAIL tie_best: got best %0d cur %0d expected 2 2", done_best, done_cur); end
    n_checks++;
    if (rev != 5) begin n_fail++; $display("FAIL tie_rev_steps: got %0d expected 5", rev); end
  endtask

  task automatic test_saturation();
    run_sweep(3, 1);
    n_checks++;
    if (scores.size() == 0 || scores[0] != 4095) begin
      n_fail++; $display("FAIL sat_score: got %0d expected 4095", (scores.size() > 0) ? scores[0] : -1);
    end
    n_checks++;
    if (done_best !== 4'd0 || rev != 7) begin n_fail++; $display("FAIL sat_best: got best %0d rev %0d expected 0 7", done_best, rev); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_handshake();
    test_reset_mid_step();
    test_reset_mid_measure();
    test_peak();
    test_tie();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/focus_sweep_ctrl.md
Name: focus_sweep_ctrl

Overview:
- Autofocus sequencer for the motor-camera focus path.
- Steps the focus motor through MAX_POS positions and waits SETTLE_FRAMES frames after each move.
- At each position it gates the Sobel edge datapath on and sums the per-pixel gradient magnitude (integrated_data) over a fixed ROI for one frame, giving a sharpness score.
- After the sweep it drives the motor back to the best-scoring position. Sits between the VGA/camera timing, the Sobel filter and the motor driver.

Parameters:
- MAX_POS, 32, number of focus positions swept (0..MAX_POS-1).
- POS_W, 6, width of position outputs; must satisfy 2^POS_W >= MAX_POS.
- SETTLE_FRAMES, 2, whole frames discarded after each motor step before measuring.
- ROI_X0, 80, first ROI column (inclusive).
- ROI_X1, 239, last ROI column (inclusive).
- ROI_Y0, 60, first ROI row (inclusive).
- ROI_Y1, 179, last ROI row (inclusive).
- SCORE_W, 28, accumulator/score width.

Ports:
- clk_25MHz  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins sweep; ignored unless IDLE.
- frame_start  in  1  one-cycle pulse at start of each frame.
- pixel_valid  in  1  x_pixel/y_pixel/integrated_data valid this cycle.
- x_pixel  in  10  current column (0..319).
- y_pixel  in  10  current row (0..239).
- integrated_data  in  11  unsigned |Gx|+|Gy| from the Sobel datapath.
- step_ack  in  1  one-cycle pulse from motor driver: step completed.
- sobel_en  out  1  Sobel line-buffer write enable.
- step_req  out  1  motor step request, held until step_ack.
- step_dir  out  1  1 = toward higher position, 0 = lower; stable while step_req=1.
- cur_pos  out  POS_W  current motor position.
- best_pos  out  POS_W  position of highest score so far.
- focus_score  out  SCORE_W  score of last measured frame.
- score_valid  out  1  one-cycle pulse when focus_score updates.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on sweep completion.

Behaviour:
- Reset values: all outputs 0; state IDLE; best_score 0; accumulator 0.
- Reset asserted mid-operation: return to IDLE immediately and deassert step_req; no resume.
- States: IDLE, SETTLE, MEASURE, COMPARE, STEP, RETURN, FINISH.
- IDLE, start=1:
  - cur_pos<=0, best_pos<=0, best_score<=0, frame counter<=0.
  - Next state SETTLE.
- SETTLE:
  - Counts frame_start pulses.
  - On the (SETTLE_FRAMES+1)-th pulse: clear accumulator, enter MEASURE. That pulse opens the measured frame.
- MEASURE:
  - Each cycle with pixel_valid=1 and x in [ROI_X0,ROI_X1] and y in [ROI_Y0,ROI_Y1]: acc <= acc + integrated_data (zero-extended).
  - Saturates at 2^SCORE_W-1 and never wraps.
  - On next frame_start: go to COMPARE. Pixels in that same cycle are not accumulated.
- COMPARE (1 cycle):
  - focus_score<=acc; score_valid=1.
  - If acc > best_score (strict), then best_score<=acc and best_pos<=cur_pos. Ties keep the earlier position.
  - If cur_pos==MAX_POS-1, go to RETURN; else go to STEP with step_dir=1.
- STEP:
  - step_req=1 until step_ack.
  - On step_ack: cur_pos += 1 (dir=1) or -= 1 (dir=0), step_req<=0 on the same edge.
  - Next state is SETTLE when sweeping, RETURN when returning.
  - step_ack outside STEP is ignored.
- RETURN:
  - If cur_pos > best_pos: step_dir=0, go to STEP.
  - Else go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- sobel_en = 1 in SETTLE, MEASURE and COMPARE; 0 elsewhere. Settle frames refill the line buffers.
- start while busy: ignored.
- Latencies:
  - start to SETTLE: 1 cycle.
  - Measured-frame-end frame_start to score_valid: 1 cycle.
- Max raw sum for default ROI: 19200*2047 < 2^28, so saturation is unreachable with defaults. It is still required for reduced SCORE_W.

Test Plan:
- Reset/idle: hold reset=0 then release, no start → all outputs 0; frame_start and step_ack pulses cause no change.
- Constant input, MAX_POS=2, SETTLE_FRAMES=1: integrated_data=10 on all valid pixels of full 320x240 frames → first score_valid with focus_score=192000; exactly one step_req (dir=1) after it.
- Peak sweep, MAX_POS=8: ROI pixels carry integrated_data = 100 - 10*|pos-5| → 7 forward acks, then 2 reverse acks (dir=0); done with best_pos=5, cur_pos=5, busy falls the cycle after done.
- Tie: scores equal maxima at pos 2 and 6 (MAX_POS=8) → best_pos=2; 5 reverse steps.
- Handshake: step_ack delayed 100 cycles → step_req and step_dir stable throughout; cur_pos changes only on the ack edge. A start pulse mid-sweep and a stray step_ack in MEASURE have no effect.
- Reset mid-MEASURE and mid-STEP: reset=0 → step_req, sobel_en, busy = 0 asynchronously. After release, a new start runs a clean sweep from cur_pos=0.
